// File: rtl/ddr_burst_writer_if.sv
// ddr_burst_writer_if: pixel input, DDR burst request/data and frame status bundle
interface ddr_burst_writer_if #(
  parameter int ADDR_W  = 24,
  parameter int FIFO_AW = 8
);
  logic [23:0]        frame_words;
  logic               frame_start;
  logic               pix_wr_en;
  logic [15:0]        pix_wr_data;
  logic               burst_req;
  logic [ADDR_W-1:0]  burst_addr;
  logic [7:0]         burst_len;
  logic               burst_ack;
  logic [15:0]        burst_data;
  logic               burst_data_rd;
  logic               frame_done;
  logic [FIFO_AW:0]   fifo_level;
  logic               overflow;
  modport slave (
    input  frame_words, frame_start, pix_wr_en, pix_wr_data, burst_ack, burst_data_rd,
    output burst_req, burst_addr, burst_len, burst_data, frame_done, fifo_level, overflow
  );
  modport master (
    output frame_words, frame_start, pix_wr_en, pix_wr_data, burst_ack, burst_data_rd,
    input  burst_req, burst_addr, burst_len, burst_data, frame_done, fifo_level, overflow
  );
endinterface

// File: rtl/ddr_burst_writer.sv
// ddr_burst_writer: buffers RGB565 pixels in a FWFT FIFO and issues linear DDR write bursts per frame
module ddr_burst_writer #(
  parameter int                BURST_LEN = 64,
  parameter int                FIFO_AW   = 8,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic              clk,
  input logic              rst_n,
  ddr_burst_writer_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t             r_state, w_next;
  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic [ADDR_W-1:0]  r_addr, r_burst_addr;
  logic [23:0]        r_rem;
  logic [7:0]         r_burst_len, r_cnt;
  logic               r_pend, r_armed, r_done, r_ovf;
  logic               w_arm, w_go, w_rd, w_wr, w_drop, w_last, w_frame_end;
  logic [23:0]        w_n, w_rem_next;
  // Handshake qualifiers; arming owns the whole cycle so a same-cycle pixel is discarded with the flush
  always_comb begin
    w_arm       = r_state == IDLE && r_pend;
    w_n         = r_rem < 24'(BURST_LEN) ? r_rem : 24'(BURST_LEN);
    w_go        = r_state == IDLE && !r_pend && r_armed && w_n != '0 && 24'(r_level) >= w_n;
    w_rd        = r_state == DATA && bus.burst_data_rd && r_level != '0;
    w_wr        = bus.pix_wr_en && r_armed && !w_arm && (!r_level[FIFO_AW] || w_rd);
    w_drop      = bus.pix_wr_en && r_armed && !w_arm && !w_wr;
    w_last      = w_rd && r_cnt == r_burst_len - 8'd1;
    w_rem_next  = r_rem - 24'(r_burst_len);
    w_frame_end = w_last && w_rem_next == '0;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // FSM next state
  always_comb
    w_next = r_state == IDLE ? (w_go ? REQ : IDLE) :
             r_state == REQ  ? (bus.burst_ack ? DATA : REQ) :
             r_state == DATA ? (w_last ? IDLE : DATA) : IDLE;
  // Outputs; the head word reads as zero while the FIFO is empty
  always_comb begin
    bus.burst_req  = r_state == REQ;
    bus.burst_addr = r_burst_addr;
    bus.burst_len  = r_burst_len;
    bus.burst_data = r_level != '0 ? r_mem[r_rptr] : '0;
    bus.frame_done = r_done;
    bus.fifo_level = r_level;
    bus.overflow   = r_ovf;
  end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (w_arm) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_rd) r_rptr <= r_rptr + FIFO_AW'(1);
      r_level <= r_level + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_rd);
      if (w_drop) r_ovf <= 1'b1;
    end
  // FIFO storage
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= bus.pix_wr_data;
  // Frame arming, burst descriptor and address/remaining bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_rem        <= '0;
      r_burst_addr <= BASE_ADDR;
      r_burst_len  <= '0;
      r_cnt        <= '0;
    end else begin
      r_pend <= bus.frame_start || (r_pend && !w_arm);
      r_done <= w_frame_end;
      if (w_arm) begin
        r_addr  <= BASE_ADDR;
        r_rem   <= bus.frame_words;
        r_armed <= bus.frame_words != '0;
      end
      if (w_go) begin
        r_burst_addr <= r_addr;
        r_burst_len  <= 8'(w_n);
      end
      if (r_state == REQ && bus.burst_ack) r_cnt <= '0;
      else if (w_rd)                       r_cnt <= r_cnt + 8'd1;
      if (w_last) begin
        r_addr <= w_frame_end ? BASE_ADDR : r_addr + ADDR_W'(r_burst_len);
        r_rem  <= w_rem_next;
        if (w_frame_end) begin
          r_armed      <= 1'b0;
          r_burst_addr <= BASE_ADDR;
        end
      end
    end
endmodule

// File: tb/tb_ddr_burst_writer.sv
// tb_ddr_burst_writer: table-driven frames plus scoreboarded corner sequences for ddr_burst_writer
module tb_ddr_burst_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_burst_writer_if #(.ADDR_W(24), .FIFO_AW(8)) bus ();
  ddr_burst_writer #(.BURST_LEN(64), .FIFO_AW(8), .ADDR_W(24), .BASE_ADDR(24'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [23:0] fw;
    logic [15:0] pbase;
    int          nb;
    int          tail;
  } vec_t;
  vec_t vecs[6];

  logic [15:0] q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input logic [23:0] fw);
    bus.frame_words = fw;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input int n, input logic [15:0] base, input int lim);
    for (int i = 0; i < n; i++) begin
      bus.pix_wr_en   = 1'b1;
      bus.pix_wr_data = base + 16'(i);
      if (i < lim) q.push_back(base + 16'(i));
      @(negedge clk);
    end
    bus.pix_wr_en = 1'b0;
  endtask

  task automatic serve(input logic [23:0] ea, input int el, input bit last, input int start_at, input int dual_at);
    int t;
    logic [15:0] exp;
    logic [8:0] lvl;
    t = 0;
    while (bus.burst_req !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", bus.burst_req, 1);
    chk("burst_addr", bus.burst_addr, ea);
    chk("burst_len", bus.burst_len, el);
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    chk("req_drop", bus.burst_req, 0);
    for (int i = 0; i < el; i++) begin
      exp = q.size() > 0 ? q.pop_front() : 16'hdead;
      chk("burst_data", bus.burst_data, exp);
      lvl = bus.fifo_level;
      if (i == dual_at) begin
        bus.pix_wr_en   = 1'b1;
        bus.pix_wr_data = 16'h9000;
        q.push_back(16'h9000);
      end
      if (i == start_at) bus.frame_start = 1'b1;
      bus.burst_data_rd = 1'b1;
      @(negedge clk);
      bus.pix_wr_en   = 1'b0;
      bus.frame_start = 1'b0;
      if (i == dual_at) begin
        chk("dual_level", bus.fifo_level, lvl);
        chk("dual_ovf", bus.overflow, 0);
      end
    end
    bus.burst_data_rd = 1'b0;
    chk("frame_done", bus.frame_done, last);
    @(negedge clk);
    chk("done_pulse", bus.frame_done, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, bus.burst_req, 0);
    chk({tag, "_addr"}, bus.burst_addr, 0);
    chk({tag, "_len"}, bus.burst_len, 0);
    chk({tag, "_data"}, bus.burst_data, 0);
    chk({tag, "_done"}, bus.frame_done, 0);
    chk({tag, "_level"}, bus.fifo_level, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
  endtask

  initial begin
    int seen, bad;
    vecs[0] = '{24'd128, 16'h0000, 2, 64};
    vecs[1] = '{24'd80,  16'h0100, 2, 16};
    vecs[2] = '{24'd16,  16'h0200, 1, 16};
    vecs[3] = '{24'd64,  16'h0300, 1, 64};
    vecs[4] = '{24'd1,   16'h0400, 1, 1};
    vecs[5] = '{24'd200, 16'h0500, 4, 8};
    bus.frame_words = '0;
    bus.frame_start = 1'b0;
    bus.pix_wr_en = 1'b0;
    bus.pix_wr_data = '0;
    bus.burst_ack = 1'b0;
    bus.burst_data_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      arm(vecs[v].fw);
      chk("arm_level", bus.fifo_level, 0);
      wr(int'(vecs[v].fw), vecs[v].pbase, int'(vecs[v].fw));
      for (int b = 0; b < vecs[v].nb; b++)
        serve(24'(b * 64), b == vecs[v].nb - 1 ? vecs[v].tail : 64, b == vecs[v].nb - 1, -1, -1);
      chk("end_addr", bus.burst_addr, 0);
      chk("end_level", bus.fifo_level, 0);
      chk("end_sb", q.size(), 0);
      chk("end_ovf", bus.overflow, 0);
    end

    // full FIFO with simultaneous write+read, then re-arm requested mid-burst
    arm(24'd512);
    wr(256, 16'h1000, 256);
    chk("full_level", bus.fifo_level, 256);
    chk("full_ovf", bus.overflow, 0);
    serve(24'd0, 64, 0, -1, 0);
    bus.frame_words = 24'd64;
    serve(24'd64, 64, 0, 10, -1);
    chk("rearm_level", bus.fifo_level, 0);
    chk("rearm_ovf", bus.overflow, 0);
    chk("rearm_req", bus.burst_req, 0);
    q.delete();
    wr(64, 16'h2000, 64);
    serve(24'd0, 64, 1, -1, -1);

    // ack withheld while 300 pixels stream into a 256-deep FIFO
    arm(24'd512);
    seen = 0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      bus.pix_wr_en = 1'b1;
      bus.pix_wr_data = 16'h3000 + 16'(i);
      if (i < 256) q.push_back(16'h3000 + 16'(i));
      @(negedge clk);
      if (seen != 0 && (bus.burst_req !== 1'b1 || bus.burst_addr !== 24'd0 || bus.burst_len !== 8'd64)) bad++;
      if (bus.burst_req === 1'b1) seen = 1;
    end
    bus.pix_wr_en = 1'b0;
    chk("ovf_req_seen", seen, 1);
    chk("ovf_req_stable", bad, 0);
    chk("ovf_level", bus.fifo_level, 256);
    chk("ovf_flag", bus.overflow, 1);

    // asynchronous reset in the middle of the data phase
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pre_rst_data", bus.burst_data, q.pop_front());
      bus.burst_data_rd = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    bus.burst_data_rd = 1'b0;
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    arm(24'd64);
    wr(64, 16'h4000, 64);
    serve(24'd0, 64, 1, -1, -1);

    // pixels after frame end and with a zero-length frame are dropped silently
    wr(5, 16'h5000, 0);
    chk("post_done_level", bus.fifo_level, 0);
    chk("post_done_ovf", bus.overflow, 0);
    arm(24'd0);
    wr(3, 16'h6000, 0);
    repeat (3) @(negedge clk);
    chk("zero_fw_level", bus.fifo_level, 0);
    chk("zero_fw_ovf", bus.overflow, 0);
    chk("zero_fw_req", bus.burst_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
